// File: rtl/bp_cce_spec_table.sv
// Speculative-access metadata table: registered multi-port reads, field-masked writes,
// sequential flush sweep, and a running count of entries with spec set.
module bp_cce_spec_table
  #(parameter int num_way_groups_p = 64
  , parameter int cce_way_groups_p = 64
  , parameter int num_cce_p        = 1
  , parameter int paddr_width_p    = 40
  , parameter int addr_offset_p    = 6
  , parameter int num_rd_ports_p   = 2
  , localparam int lg_wg_lp  = (num_way_groups_p > 1) ? $clog2(num_way_groups_p) : 1
  , localparam int lg_cwg_lp = (cce_way_groups_p > 1) ? $clog2(cce_way_groups_p) : 1
  , localparam int cnt_w_lp  = $clog2(num_way_groups_p + 1)
  )
  (input  logic                                         clk_i
  , input  logic                                        reset_i
  , input  logic                                        w_v_i
  , output logic                                        w_ready_o
  , input  logic [paddr_width_p-1:0]                    w_addr_i
  , input  logic                                        w_addr_bypass_hash_i
  , input  logic [3:0]                                  w_mask_i
  , input  logic [5:0]                                  w_spec_i
  , input  logic [num_rd_ports_p-1:0]                   r_v_i
  , input  logic [num_rd_ports_p-1:0][paddr_width_p-1:0] r_addr_i
  , input  logic [num_rd_ports_p-1:0]                   r_addr_bypass_hash_i
  , output logic [num_rd_ports_p-1:0]                   r_v_o
  , output logic [num_rd_ports_p-1:0][5:0]              r_spec_o
  , input  logic                                        clear_v_i
  , output logic                                        clear_ready_o
  , output logic                                        clear_done_o
  , output logic [cnt_w_lp-1:0]                         spec_cnt_o
  );

  typedef struct packed {
    logic       spec;
    logic       squash;
    logic       fwd_mod;
    logic [2:0] state;
  } bp_cce_spec_s;

  typedef enum logic {e_ready, e_clear} state_e;

  state_e              state_r, state_n;
  logic [lg_wg_lp-1:0] sweep_idx_r, sweep_idx_n;
  bp_cce_spec_s        mem_r [num_way_groups_p];
  logic [cnt_w_lp-1:0] spec_cnt_r;

  // Hashed index: block line divided across CCEs; bypass takes the low address bits.
  function automatic logic [lg_wg_lp-1:0] map_idx(input logic [lg_cwg_lp-1:0] line,
                                                  input logic [lg_wg_lp-1:0]  low,
                                                  input logic                 bypass);
    return bypass ? low : lg_wg_lp'(32'(line) / 32'(num_cce_p));
  endfunction

  function automatic logic in_range(input logic [lg_wg_lp-1:0] idx);
    return 32'(idx) < 32'(num_way_groups_p);
  endfunction

  function automatic bp_cce_spec_s read_entry(input logic [lg_wg_lp-1:0] idx);
    return in_range(idx) ? mem_r[idx] : '0;
  endfunction

  logic unused_addr_bits;
  assign unused_addr_bits = ^{w_addr_i, r_addr_i};

  assign w_ready_o     = (state_r == e_ready);
  assign clear_ready_o = (state_r == e_ready);
  assign spec_cnt_o    = spec_cnt_r;

  logic [lg_wg_lp-1:0] w_idx;
  bp_cce_spec_s        w_cur, w_merged, w_fmask;
  logic                upd_v;
  logic [lg_wg_lp-1:0] upd_idx;
  bp_cce_spec_s        upd_dat;
  logic                upd_old_spec;

  // At most one entry changes per cycle: the sweep target in e_clear, else an accepted write.
  always_comb begin
    w_idx    = map_idx(w_addr_i[addr_offset_p +: lg_cwg_lp], w_addr_i[lg_wg_lp-1:0],
                       w_addr_bypass_hash_i);
    w_cur    = read_entry(w_idx);
    w_fmask  = {w_mask_i[0], w_mask_i[1], w_mask_i[2], {3{w_mask_i[3]}}};
    w_merged = (w_cur & ~w_fmask) | (w_spec_i & w_fmask);
    upd_v    = 1'b0;
    upd_idx  = w_idx;
    upd_dat  = w_merged;
    if (state_r == e_clear) begin
      upd_v   = 1'b1;
      upd_idx = sweep_idx_r;
      upd_dat = '0;
    end else if (w_v_i && in_range(w_idx)) begin
      upd_v = 1'b1;
    end
    upd_old_spec = read_entry(upd_idx).spec;
  end

  always_comb begin
    state_n      = state_r;
    sweep_idx_n  = sweep_idx_r;
    clear_done_o = 1'b0;
    case (state_r)
      e_ready: begin
        if (clear_v_i) begin
          state_n     = e_clear;
          sweep_idx_n = '0;
        end
      end
      e_clear: begin
        sweep_idx_n = sweep_idx_r + lg_wg_lp'(1);
        if (sweep_idx_r == lg_wg_lp'(num_way_groups_p - 1)) begin
          clear_done_o = 1'b1;
          state_n      = e_ready;
          sweep_idx_n  = '0;
        end
      end
      default: state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= e_ready;
      sweep_idx_r <= '0;
      spec_cnt_r  <= '0;
      for (int i = 0; i < num_way_groups_p; i++) mem_r[i] <= '0;
    end else begin
      state_r     <= state_n;
      sweep_idx_r <= sweep_idx_n;
      if (upd_v) begin
        mem_r[upd_idx] <= upd_dat;
        if (!upd_old_spec && upd_dat.spec)
          spec_cnt_r <= spec_cnt_r + cnt_w_lp'(1);
        else if (upd_old_spec && !upd_dat.spec)
          spec_cnt_r <= spec_cnt_r - cnt_w_lp'(1);
      end
    end
  end

  logic [lg_wg_lp-1:0] rd_idx [num_rd_ports_p];
  bp_cce_spec_s        rd_dat [num_rd_ports_p];

  // Write-first: a read of the entry being updated this cycle sees the new value.
  always_comb begin
    for (int p = 0; p < num_rd_ports_p; p++) begin
      rd_idx[p] = map_idx(r_addr_i[p][addr_offset_p +: lg_cwg_lp], r_addr_i[p][lg_wg_lp-1:0],
                          r_addr_bypass_hash_i[p]);
      rd_dat[p] = read_entry(rd_idx[p]);
      if (upd_v && (upd_idx == rd_idx[p])) rd_dat[p] = upd_dat;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_v_o    <= '0;
      r_spec_o <= '0;
    end else begin
      r_v_o <= r_v_i;
      for (int p = 0; p < num_rd_ports_p; p++)
        if (r_v_i[p]) r_spec_o[p] <= rd_dat[p];
    end
  end

endmodule
